// File: rtl/rhs_stim_pkg.sv
// Shared types and helpers for the RHS biphasic stimulation sequencer.
// ST_RECOV exists only when RHS_STIM_CHRG_RECOV_EN is defined.
package rhs_stim_pkg;

  localparam int TICK_50US_56MHZ = 2800;
  localparam int MAX_CH          = 64;
  localparam int MAX_CH_W        = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH1,
    ST_GAP,
    ST_PH2,
    ST_IPD,
    ST_DONE
`ifdef RHS_STIM_CHRG_RECOV_EN
    , ST_RECOV
`endif
  } state_e;

  // One-hot mask for channel idx; bits at or above 2**ch_w are always clear.
  function automatic logic [MAX_CH-1:0] ch_onehot(input logic [MAX_CH_W-1:0] idx,
                                                  input int                  ch_w);
    logic [MAX_CH-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      mask[i] = (i < (1 << ch_w)) && (i == int'(idx));
    end
    return mask;
  endfunction

endpackage

// File: rtl/rhs_stim_tick_gen.sv
// TICK_DIV-cycle prescaler plus a TMR_W tick down-counter for the stim sequencer.
// clear restarts the prescaler and reloads the counter, so each state gets whole ticks.
module rhs_stim_tick_gen
  import rhs_stim_pkg::*;
#(
  parameter int TICK_DIV = TICK_50US_56MHZ,
  parameter int TMR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [TMR_W-1:0] load_val,
  output logic             tick,
  output logic             tc
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [TMR_W-1:0] cnt_q, cnt_d;

  assign tick = (presc_q == PRE_W'(TICK_DIV - 1));
  assign tc   = (cnt_q == TMR_W'(1));

  always_comb begin
    // NOTE: every variable gets its default first so no path can infer a latch.
    presc_d = presc_q + PRE_W'(1);
    cnt_d   = cnt_q;
    if (clear) begin
      presc_d = '0;
      cnt_d   = load_val;
    end else if (tick) begin
      presc_d = '0;
      if (cnt_q != '0) cnt_d = cnt_q - TMR_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/rhs_stim_sequencer.sv
// Biphasic pulse-train sequencer driving per-channel stim-enable/polarity masks.
// Optional charge-recovery phase after PH2 is enabled by RHS_STIM_CHRG_RECOV_EN.
module rhs_stim_sequencer
  import rhs_stim_pkg::*;
#(
  parameter  int NUM_CH   = 32,
  parameter  int TICK_DIV = TICK_50US_56MHZ,
  parameter  int TMR_W    = 16,
  parameter  int CNT_W    = 8,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic              rhs_aclk,
  input  logic              rhs_aresetn,
  input  logic              cfg_enable,
  input  logic              cfg_trigger,
  input  logic              cfg_monopolar,
  input  logic [CH_W-1:0]   cfg_pos_ch,
  input  logic [CH_W-1:0]   cfg_neg_ch,
  input  logic [TMR_W-1:0]  cfg_pw,
  input  logic [TMR_W-1:0]  cfg_gap,
  input  logic [TMR_W-1:0]  cfg_ipd,
  input  logic [CNT_W-1:0]  cfg_npulse,
`ifdef RHS_STIM_CHRG_RECOV_EN
  input  logic [TMR_W-1:0]  cfg_recov,
  output logic [NUM_CH-1:0] chrg_recov,
`endif
  output logic [NUM_CH-1:0] stim_en,
  output logic [NUM_CH-1:0] stim_pol,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  pulse_idx
);

  typedef struct packed {
    logic              mono;
    logic [CH_W-1:0]   pos;
    logic [CH_W-1:0]   neg;
    logic [TMR_W-1:0]  pw;
    logic [TMR_W-1:0]  gap;
    logic [TMR_W-1:0]  ipd;
`ifdef RHS_STIM_CHRG_RECOV_EN
    logic [TMR_W-1:0]  recov;
`endif
    logic [CNT_W-1:0]  npulse;
  } cfg_t;

  state_e            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] en_q, en_d, pol_q, pol_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [NUM_CH-1:0] pos_m, neg_m, act_m;
  logic [TMR_W-1:0]  load_val;
  logic              tmr_clear, tick, tc, timer_done;
`ifdef RHS_STIM_CHRG_RECOV_EN
  logic [NUM_CH-1:0] recov_q, recov_d;
`endif

  rhs_stim_tick_gen #(.TICK_DIV(TICK_DIV), .TMR_W(TMR_W)) u_tick_gen (
    .clk      (rhs_aclk),
    .rst_n    (rhs_aresetn),
    .clear    (tmr_clear),
    .load_val (load_val),
    .tick     (tick),
    .tc       (tc)
  );

  assign timer_done = tick & tc;

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    if (!cfg_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cfg_trigger) begin
          if (!cfg_monopolar && (cfg_pos_ch == cfg_neg_ch)) begin
            err_d = 1'b1;
          end else begin
            // Zero widths/delays are clamped once here so every phase sees >= 1 tick.
            cfg_d.mono   = cfg_monopolar;
            cfg_d.pos    = cfg_pos_ch;
            cfg_d.neg    = cfg_neg_ch;
            cfg_d.pw     = (cfg_pw == '0) ? TMR_W'(1) : cfg_pw;
            cfg_d.gap    = cfg_gap;
            cfg_d.ipd    = (cfg_ipd == '0) ? TMR_W'(1) : cfg_ipd;
`ifdef RHS_STIM_CHRG_RECOV_EN
            cfg_d.recov  = cfg_recov;
`endif
            cfg_d.npulse = cfg_npulse;
            idx_d        = '0;
            state_d      = ST_PH1;
          end
        end
        ST_PH1: if (timer_done) state_d = (cfg_q.gap != '0) ? ST_GAP : ST_PH2;
        ST_GAP: if (timer_done) state_d = ST_PH2;
        ST_PH2: if (timer_done) begin
`ifdef RHS_STIM_CHRG_RECOV_EN
          state_d = (cfg_q.recov != '0) ? ST_RECOV : ST_IPD;
`else
          state_d = ST_IPD;
`endif
        end
`ifdef RHS_STIM_CHRG_RECOV_EN
        ST_RECOV: if (timer_done) state_d = ST_IPD;
`endif
        ST_IPD: if (timer_done) begin
          if (idx_q == cfg_q.npulse) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = ST_PH1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    tmr_clear = (state_d != state_q);
    case (state_d)
      ST_PH1, ST_PH2: load_val = cfg_d.pw;
      ST_GAP:         load_val = cfg_d.gap;
      ST_IPD:         load_val = cfg_d.ipd;
`ifdef RHS_STIM_CHRG_RECOV_EN
      ST_RECOV:       load_val = cfg_d.recov;
`endif
      default:        load_val = '0;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    pos_m = NUM_CH'(ch_onehot(MAX_CH_W'(cfg_d.pos), CH_W));
    neg_m = cfg_d.mono ? '0 : NUM_CH'(ch_onehot(MAX_CH_W'(cfg_d.neg), CH_W));
    act_m = pos_m | neg_m;
    en_d  = '0;
    pol_d = '0;
`ifdef RHS_STIM_CHRG_RECOV_EN
    recov_d = '0;
    if (state_d == ST_RECOV) recov_d = act_m;
`endif
    if (state_d == ST_PH1) begin
      en_d  = act_m;
      pol_d = neg_m;
    end else if (state_d == ST_PH2) begin
      en_d  = act_m;
      pol_d = pos_m;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = cfg_enable && (state_q == ST_DONE);
  end

  always_ff @(posedge rhs_aclk or negedge rhs_aresetn) begin
    if (!rhs_aresetn) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      idx_q   <= '0;
      en_q    <= '0;
      pol_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef RHS_STIM_CHRG_RECOV_EN
      recov_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      pol_q   <= pol_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef RHS_STIM_CHRG_RECOV_EN
      recov_q <= recov_d;
`endif
    end
  end

  assign stim_en   = en_q;
  assign stim_pol  = pol_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = err_q;
  assign pulse_idx = idx_q;
`ifdef RHS_STIM_CHRG_RECOV_EN
  assign chrg_recov = recov_q;
`endif

endmodule

// File: tb/tb_rhs_stim_sequencer.sv
// Bench for rhs_stim_sequencer: a train-expansion model compared every cycle,
// plus hand-computed literal expectations for each directed scenario.
module tb_rhs_stim_sequencer;

  localparam int NUM_CH   = 32;
  localparam int TICK_DIV = 4;
  localparam int TMR_W    = 16;
  localparam int CNT_W    = 8;
  localparam int CH_W     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_enable = 1'b1;
  logic              cfg_trigger = 1'b0;
  logic              cfg_monopolar = 1'b0;
  logic [CH_W-1:0]   cfg_pos_ch = '0;
  logic [CH_W-1:0]   cfg_neg_ch = '0;
  logic [TMR_W-1:0]  cfg_pw = '0;
  logic [TMR_W-1:0]  cfg_gap = '0;
  logic [TMR_W-1:0]  cfg_ipd = '0;
  logic [CNT_W-1:0]  cfg_npulse = '0;
  logic [NUM_CH-1:0] stim_en, stim_pol, chrg_recov;
  logic              busy, done, cfg_err;
  logic [CNT_W-1:0]  pulse_idx;
`ifdef RHS_STIM_CHRG_RECOV_EN
  logic [TMR_W-1:0]  cfg_recov = '0;
`else
  assign chrg_recov = '0;
`endif

  always #5 clk = ~clk;

  rhs_stim_sequencer #(
    .NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .TMR_W(TMR_W), .CNT_W(CNT_W)
  ) dut (
    .rhs_aclk      (clk),
    .rhs_aresetn   (rst_n),
    .cfg_enable    (cfg_enable),
    .cfg_trigger   (cfg_trigger),
    .cfg_monopolar (cfg_monopolar),
    .cfg_pos_ch    (cfg_pos_ch),
    .cfg_neg_ch    (cfg_neg_ch),
    .cfg_pw        (cfg_pw),
    .cfg_gap       (cfg_gap),
    .cfg_ipd       (cfg_ipd),
    .cfg_npulse    (cfg_npulse),
`ifdef RHS_STIM_CHRG_RECOV_EN
    .cfg_recov     (cfg_recov),
    .chrg_recov    (chrg_recov),
`endif
    .stim_en       (stim_en),
    .stim_pol      (stim_pol),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .pulse_idx     (pulse_idx)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Model: one entry per clock cycle of expected outputs, expanded from the train rules.
  typedef struct {
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] pol;
    logic [NUM_CH-1:0] chrg;
    logic              busy;
    logic              done;
    int                idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_cur = '{default: '0};
  logic exp_err = 1'b0;

  function automatic exp_t mk(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] pol,
                              input logic [NUM_CH-1:0] chrg, input logic b, input logic d,
                              input int idx);
    exp_t e;
    e.en = en; e.pol = pol; e.chrg = chrg; e.busy = b; e.done = d; e.idx = idx;
    return e;
  endfunction

  function automatic void build_train();
    logic [NUM_CH-1:0] pos_m, neg_m, act_m;
    int pw, gap, ipd, rec, np;
    pos_m = '0;
    pos_m[cfg_pos_ch] = 1'b1;
    neg_m = '0;
    if (!cfg_monopolar) neg_m[cfg_neg_ch] = 1'b1;
    act_m = pos_m | neg_m;
    pw  = (cfg_pw == 0) ? 1 : int'(cfg_pw);
    gap = int'(cfg_gap);
    ipd = (cfg_ipd == 0) ? 1 : int'(cfg_ipd);
    rec = 0;
`ifdef RHS_STIM_CHRG_RECOV_EN
    rec = int'(cfg_recov);
`endif
    np  = int'(cfg_npulse);
    for (int p = 0; p <= np; p++) begin
      for (int c = 0; c < pw * TICK_DIV; c++)  exp_q.push_back(mk(act_m, neg_m, '0, 1'b1, 1'b0, p));
      for (int c = 0; c < gap * TICK_DIV; c++) exp_q.push_back(mk('0, '0, '0, 1'b1, 1'b0, p));
      for (int c = 0; c < pw * TICK_DIV; c++)  exp_q.push_back(mk(act_m, pos_m, '0, 1'b1, 1'b0, p));
      for (int c = 0; c < rec * TICK_DIV; c++) exp_q.push_back(mk('0, '0, act_m, 1'b1, 1'b0, p));
      for (int c = 0; c < ipd * TICK_DIV; c++) exp_q.push_back(mk('0, '0, '0, 1'b1, 1'b0, p));
    end
    exp_q.push_back(mk('0, '0, '0, 1'b1, 1'b0, np));
    exp_q.push_back(mk('0, '0, '0, 1'b0, 1'b1, np));
  endfunction

  // Model update: inputs are sampled at each rising edge, predicting the following cycle.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      exp_err = 1'b0;
      if (!rst_n || !cfg_enable) begin
        exp_q.delete();
        exp_cur = mk('0, '0, '0, 1'b0, 1'b0, 0);
      end else if (exp_q.size() != 0) begin
        exp_cur = exp_q.pop_front();
      end else if (cfg_trigger && !cfg_monopolar && (cfg_pos_ch == cfg_neg_ch)) begin
        exp_cur = mk('0, '0, '0, 1'b0, 1'b0, 0);
        exp_err = 1'b1;
      end else if (cfg_trigger) begin
        build_train();
        exp_cur = exp_q.pop_front();
      end else begin
        exp_cur = mk('0, '0, '0, 1'b0, 1'b0, 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cmp_stim_en", 64'(stim_en), 64'(exp_cur.en));
      check("cmp_stim_pol", 64'(stim_pol), 64'(exp_cur.pol));
      check("cmp_chrg_recov", 64'(chrg_recov), 64'(exp_cur.chrg));
      check("cmp_busy", 64'(busy), 64'(exp_cur.busy));
      check("cmp_done", 64'(done), 64'(exp_cur.done));
      check("cmp_cfg_err", 64'(cfg_err), 64'(exp_err));
      if (exp_cur.busy) check("cmp_pulse_idx", 64'(pulse_idx), 64'(exp_cur.idx));
    end
  end

  logic [NUM_CH-1:0] en_log[0:511];
  logic [NUM_CH-1:0] pol_log[0:511];
  logic [NUM_CH-1:0] chrg_log[0:511];

  task automatic set_cfg(input bit mono, input int pos, input int neg, input int pw,
                         input int gap, input int ipd, input int np, input int rec);
    cfg_monopolar = mono;
    cfg_pos_ch    = CH_W'(pos);
    cfg_neg_ch    = CH_W'(neg);
    cfg_pw        = TMR_W'(pw);
    cfg_gap       = TMR_W'(gap);
    cfg_ipd       = TMR_W'(ipd);
    cfg_npulse    = CNT_W'(np);
`ifdef RHS_STIM_CHRG_RECOV_EN
    cfg_recov     = TMR_W'(rec);
`else
    if (rec != 0) $display("note: recovery time ignored in this build");
`endif
  endtask

  // Called just after a rising edge; returns just after the edge that sampled the trigger.
  task automatic fire();
    cfg_trigger = 1'b1;
    @(posedge clk);
    #1 cfg_trigger = 1'b0;
  endtask

  // Logs each cycle until busy drops (bounded); busy_cyc counts busy cycles seen.
  task automatic observe(input int max_cyc, output int busy_cyc, output logic done_seen);
    busy_cyc  = 0;
    done_seen = 1'b0;
    for (int i = 1; i <= max_cyc && i < 512; i++) begin
      @(negedge clk);
      en_log[i]   = stim_en;
      pol_log[i]  = stim_pol;
      chrg_log[i] = chrg_recov;
      if (busy) begin
        busy_cyc++;
      end else begin
        done_seen = done;
        break;
      end
    end
  endtask

  int   bc;
  logic ds;
  logic found;

  initial begin
    #3;
    check("rst_stim_en", 64'(stim_en), 64'h0);
    check("rst_stim_pol", 64'(stim_pol), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_cfg_err", 64'(cfg_err), 64'h0);
    check("rst_pulse_idx", 64'(pulse_idx), 64'h0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Bipolar 17/18, pw=2 ticks (8 cycles), no gap, ipd=16 ticks, two pulses.
    set_cfg(0, 17, 18, 2, 0, 16, 1, 0);
    fire();
    observe(400, bc, ds);
    check("t1_busy_cycles", 64'(bc), 64'd161);
    check("t1_done_pulse", 64'(ds), 64'h1);
    check("t1_ph1_en", 64'(en_log[1]), 64'h0006_0000);
    check("t1_ph1_pol", 64'(pol_log[1]), 64'h0004_0000);
    check("t1_ph1_last_pol", 64'(pol_log[8]), 64'h0004_0000);
    check("t1_ph2_pol", 64'(pol_log[9]), 64'h0002_0000);
    check("t1_ph2_last_en", 64'(en_log[16]), 64'h0006_0000);
    check("t1_ipd_en", 64'(en_log[17]), 64'h0);
    check("t1_p2_en", 64'(en_log[81]), 64'h0006_0000);
    @(posedge clk); #1;

    // Monopolar ch0, pw=0 (one tick), gap=2 ticks, single pulse.
    set_cfg(1, 0, 3, 0, 2, 1, 0, 0);
    fire();
    observe(100, bc, ds);
    check("t2_busy_cycles", 64'(bc), 64'd21);
    check("t2_ph1_en", 64'(en_log[4]), 64'h1);
    check("t2_ph1_pol", 64'(pol_log[4]), 64'h0);
    check("t2_gap_first", 64'(en_log[5]), 64'h0);
    check("t2_gap_last", 64'(en_log[12]), 64'h0);
    check("t2_ph2_en", 64'(en_log[13]), 64'h1);
    check("t2_ph2_pol", 64'(pol_log[13]), 64'h1);
    check("t2_ipd_en", 64'(en_log[17]), 64'h0);
    @(posedge clk); #1;

    // Invalid bipolar pair 5/5.
    set_cfg(0, 5, 5, 1, 0, 1, 0, 0);
    fire();
    @(negedge clk);
    check("t3_cfg_err", 64'(cfg_err), 64'h1);
    check("t3_busy", 64'(busy), 64'h0);
    check("t3_stim_en", 64'(stim_en), 64'h0);
    @(negedge clk);
    check("t3_cfg_err_pulse", 64'(cfg_err), 64'h0);
    @(posedge clk); #1;

    // Trigger in the same cycle enable falls: no start.
    set_cfg(0, 17, 18, 1, 0, 1, 0, 0);
    cfg_enable = 1'b0;
    fire();
    @(negedge clk);
    check("t3b_enable_wins", 64'(busy), 64'h0);
    cfg_enable = 1'b1;
    @(posedge clk); #1;

    // Eight pulses, abort during PH2 of the third, then restart.
    set_cfg(0, 17, 18, 1, 1, 1, 7, 0);
    fire();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pulse_idx == CNT_W'(2) && stim_pol[17]) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_reached_ph2_p3", 64'(found), 64'h1);
    cfg_enable = 1'b0;
    @(negedge clk);
    check("t4_abort_en", 64'(stim_en), 64'h0);
    check("t4_abort_pol", 64'(stim_pol), 64'h0);
    check("t4_abort_busy", 64'(busy), 64'h0);
    @(negedge clk);
    check("t4_abort_no_done", 64'(done), 64'h0);
    @(posedge clk); #1 cfg_enable = 1'b1;
    @(posedge clk); #1;
    fire();
    @(negedge clk);
    check("t4_restart_idx", 64'(pulse_idx), 64'h0);
    check("t4_restart_busy", 64'(busy), 64'h1);
    observe(400, bc, ds);
    check("t4_restart_rest", 64'(bc), 64'd128);
    @(posedge clk); #1;

    // Re-trigger with a changed pw mid-train: latched timing must hold.
    set_cfg(0, 17, 18, 2, 0, 2, 1, 0);
    fire();
    repeat (3) @(posedge clk);
    #1 cfg_pw = TMR_W'(5);
    fire();
    observe(200, bc, ds);
    check("t5_busy_rest", 64'(bc), 64'd45);
    check("t5_ph1_last_pol", 64'(pol_log[4]), 64'h0004_0000);
    check("t5_ph2_pol", 64'(pol_log[5]), 64'h0002_0000);
    @(posedge clk); #1;

    // Reset asserted mid-PH1 clears outputs without waiting for a clock.
    set_cfg(0, 17, 18, 3, 0, 1, 0, 0);
    fire();
    @(posedge clk); #1;
    check("t6_pre_reset_en", 64'(stim_en), 64'h0006_0000);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_en", 64'(stim_en), 64'h0);
    check("t6_rst_pol", 64'(stim_pol), 64'h0);
    check("t6_rst_busy", 64'(busy), 64'h0);
    check("t6_rst_idx", 64'(pulse_idx), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef RHS_STIM_CHRG_RECOV_EN
    // Charge recovery of 3 ticks between PH2 and IPD.
    set_cfg(0, 17, 18, 2, 0, 16, 0, 3);
    fire();
    observe(200, bc, ds);
    check("t7_busy_cycles", 64'(bc), 64'd93);
    check("t7_ph2_last_en", 64'(en_log[16]), 64'h0006_0000);
    check("t7_recov_first", 64'(chrg_log[17]), 64'h0006_0000);
    check("t7_recov_en", 64'(en_log[17]), 64'h0);
    check("t7_recov_last", 64'(chrg_log[28]), 64'h0006_0000);
    check("t7_recov_end", 64'(chrg_log[29]), 64'h0);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
